// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes ALU SUB flags + funct3 into a branch decision, buffered in a 2-entry skid FIFO.
// Optional per-decision statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         zero,
  input  logic         negative,
  input  logic         carry,
  input  logic         overflow,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [N-1:0] target,
  output logic         illegal
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]  stat_taken,
  output logic [15:0]  stat_not_taken,
  output logic [15:0]  stat_illegal
`endif
);

  generate
    if (DEPTH != 2) begin : g_depth_err
      $error("branch_resolve_unit: DEPTH must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_in_ready, r_out_valid;
  logic         w_push, w_pop, w_ld_head, w_ld_tail, w_shift;
  logic         w_cond, w_illegal;
  logic [N-1:0] w_target;
  logic         r_hd_taken, r_hd_illegal, r_tl_taken, r_tl_illegal;
  logic [N-1:0] r_hd_target, r_tl_target;

  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = r_out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign taken     = r_hd_taken;
  assign illegal   = r_hd_illegal;
  assign target    = r_hd_target;

  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (funct3)
      3'b000:         w_cond = zero;
      3'b001:         w_cond = ~zero;
      3'b100:         w_cond = negative ^ overflow;
      3'b101:         w_cond = ~(negative ^ overflow);
      3'b110:         w_cond = ~carry;
      3'b111:         w_cond = carry;
      default:        w_illegal = 1'b1;
    endcase
  end

  // Modulo-2^N adds; carry-out intentionally dropped
  assign w_target = w_cond ? (pc + imm) : (pc + {{(N-3){1'b0}}, 3'd4});

  always_comb begin
    w_state_nxt = r_state;
    w_ld_head   = 1'b0;
    w_ld_tail   = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_ld_head   = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_ld_head = 1'b1;
        end else if (w_push) begin
          w_state_nxt = S_FULL;
          w_ld_tail   = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_shift     = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  // Storage is reset too so the idle output reads zero after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hd_taken   <= 1'b0;
      r_hd_illegal <= 1'b0;
      r_hd_target  <= '0;
      r_tl_taken   <= 1'b0;
      r_tl_illegal <= 1'b0;
      r_tl_target  <= '0;
    end else begin
      if (w_ld_head) begin
        r_hd_taken   <= w_cond;
        r_hd_illegal <= w_illegal;
        r_hd_target  <= w_target;
      end else if (w_shift) begin
        r_hd_taken   <= r_tl_taken;
        r_hd_illegal <= r_tl_illegal;
        r_hd_target  <= r_tl_target;
      end
      if (w_ld_tail) begin
        r_tl_taken   <= w_cond;
        r_tl_illegal <= w_illegal;
        r_tl_target  <= w_target;
      end
    end
  end

`ifdef BRU_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_stat_taken, r_stat_not_taken, r_stat_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_taken     <= '0;
      r_stat_not_taken <= '0;
      r_stat_illegal   <= '0;
    end else if (w_pop) begin
      if (r_hd_illegal)    r_stat_illegal   <= sat_inc(r_stat_illegal);
      else if (r_hd_taken) r_stat_taken     <= sat_inc(r_stat_taken);
      else                 r_stat_not_taken <= sat_inc(r_stat_not_taken);
    end
  end

  assign stat_taken     = r_stat_taken;
  assign stat_not_taken = r_stat_not_taken;
  assign stat_illegal   = r_stat_illegal;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: operands drive ALU-style flags, reference decides from plain comparisons.
module tb_branch_resolve_unit;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic          zero, negative, carry, overflow;
  logic [2:0]    funct3;
  logic [N-1:0]  pc, imm;
  logic          out_valid, out_ready;
  logic          taken, illegal;
  logic [N-1:0]  target;
`ifdef BRU_STATS_EN
  logic [15:0]   stat_taken, stat_not_taken, stat_illegal;
`endif

  branch_resolve_unit #(.N(N), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .funct3(funct3), .pc(pc), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target), .illegal(illegal)
`ifdef BRU_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken), .stat_illegal(stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic [31:0] target;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_taken = 0, n_not_taken = 0, n_illegal = 0;
  int   rdy_mode = 1;  // 0 low, 1 high, 2 random

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: branch outcome straight from operand comparison
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                 input logic [31:0] p, input logic [31:0] im);
    exp_t e;
    logic t;
    e.illegal = 1'b0;
    case (f3)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = ($signed(a) <  $signed(b));
      3'd5:    t = ($signed(a) >= $signed(b));
      3'd6:    t = (a <  b);
      3'd7:    t = (a >= b);
      default: begin t = 1'b0; e.illegal = 1'b1; end
    endcase
    e.taken  = t;
    e.target = t ? p + im : p + 32'd4;
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic [31:0] p, input logic [31:0] im);
    logic [32:0] d;
    d        = {1'b0, a} - {1'b0, b};
    zero     = (d[31:0] == 32'd0);
    negative = d[31];
    carry    = ~d[32];
    overflow = (a[31] != b[31]) && (d[31] != a[31]);
    funct3   = f3;
    pc       = p;
    imm      = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [31:0] p, input logic [31:0] im);
    int w;
    @(negedge clk);
    drive(a, b, f3, p, im);
    #1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
      in_valid = 1'b0;
      return;
    end
    sbq.push_back(model(a, b, f3, p, im));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: head must match scoreboard front whenever valid (also covers hold stability)
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got out_valid=1 target=0x%0h, expected no output", target);
        end else begin
          e = sbq[0];
          chk("taken",   32'(taken),   32'(e.taken));
          chk("illegal", 32'(illegal), 32'(e.illegal));
          chk("target",  target,       e.target);
          if (out_ready) begin
            void'(sbq.pop_front());
            if (e.illegal)    n_illegal++;
            else if (e.taken) n_taken++;
            else              n_not_taken++;
          end
        end
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_taken"},     32'(taken),     32'd0);
    chk({tag, "_illegal"},   32'(illegal),   32'd0);
    chk({tag, "_target"},    target,         32'd0);
`ifdef BRU_STATS_EN
    chk({tag, "_stat_taken"},     32'(stat_taken),     32'd0);
    chk({tag, "_stat_not_taken"}, 32'(stat_not_taken), 32'd0);
    chk({tag, "_stat_illegal"},   32'(stat_illegal),   32'd0);
`endif
  endtask

  initial begin
    logic [31:0] a, b;
    int w;
    rst = 1'b1;
    in_valid = 1'b0; zero = 1'b0; negative = 1'b0; carry = 1'b0; overflow = 1'b0;
    funct3 = 3'd0; pc = '0; imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("reset");

    // Equal operands, BEQ, one-cycle latency
    send(32'd5, 32'd5, 3'b000, 32'h100, 32'h20);
    chk("t1_latency", 32'(out_valid), 32'd1);
    chk("t1_target",  target,         32'h120);
    repeat (2) @(negedge clk);

    // Signed vs unsigned on identical flags; overflow cases
    send(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h200, 32'h40);
    send(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h200, 32'h40);
    send(32'h8000_0000, 32'd1, 3'b100, 32'h300, 32'h10);
    send(32'h8000_0000, 32'd1, 3'b101, 32'h300, 32'h10);
    repeat (3) @(negedge clk);

    // Target wrap and illegal funct3
    send(32'd3, 32'd4, 3'b001, 32'hFFFF_FFF0, 32'h20);
    chk("t5_wrap", target, 32'h0000_0010);
    repeat (2) @(negedge clk);
    send(32'd7, 32'd7, 3'b010, 32'h400, 32'h8);
    chk("t5_illegal", 32'(illegal), 32'd1);
    chk("t5_ill_tgt", target, 32'h404);
    repeat (3) @(negedge clk);

    // Backpressure: two accepted, third held, then in-order drain
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(32'd1, 32'd2, 3'b110, 32'h500, 32'h100);
    send(32'd9, 32'd2, 3'b111, 32'h600, 32'h200);
    chk("t4_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    drive(32'd2, 32'd2, 3'b000, 32'h700, 32'h300);
    #1;
    chk("t4_held", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("t4_held2", 32'(in_ready), 32'd0);
    rdy_mode = 1;
    send(32'd2, 32'd2, 3'b000, 32'h700, 32'h300);
    repeat (4) @(negedge clk);

    // Reset with the FIFO full
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(32'd1, 32'd1, 3'b000, 32'h800, 32'h4);
    send(32'd1, 32'd2, 3'b100, 32'h900, 32'h8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",  32'(out_valid), 32'd0);
    chk("t6_rst_target", target,         32'd0);
    sbq.delete();
    n_taken = 0; n_not_taken = 0; n_illegal = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("t6");

    // Randomized traffic under random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      send(a, b, 3'($urandom_range(0, 7)), $urandom(), $urandom());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    rdy_mode = 1;
    w = 0;
    while (sbq.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_left", 32'(sbq.size()), 32'd0);
`ifdef BRU_STATS_EN
    chk("stat_taken",     32'(stat_taken),     32'(n_taken));
    chk("stat_not_taken", 32'(stat_not_taken), 32'(n_not_taken));
    chk("stat_illegal",   32'(stat_illegal),   32'(n_illegal));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
